mod_exp_ct: RTL
===============

# mod_exp_ct

Constant-time modular exponentiator for the RSA datapath. It computes out = base^exp mod n with a Montgomery-ladder schedule and interleaved shift-add modular multiplication. Latency depends only on WIDTH, never on operand values. It sits directly downstream of key generation and consumes its e/d/n outputs: encryption is c = m^e mod n, decryption is m = c^d mod n.

## Interface
- WIDTH, 8, prime width; the modulus, exponent and data are 2*WIDTH bits wide.
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request pulse; sampled only when the block is able to accept.
- base  input  2*WIDTH  message or ciphertext; the caller guarantees base < n.
- exp  input  2*WIDTH  exponent (e zero-extended, or d).
- n  input  2*WIDTH  modulus; odd in normal use.
- out  output  2*WIDTH  result; registered.
- busy  output  1  high while a computation is in flight.
- finish  output  1  one-cycle pulse: out is valid.

## Operation
- States: IDLE, INIT, MUL, STEP, DONE.
- **Capture.** In IDLE or DONE, start=1 latches base, exp and n into internal registers and moves to INIT. Input changes after capture have no effect.
- **INIT.** Load R0 = (n==1 ? 0 : 1) and R1 = base. Set bit index i = 2*WIDTH-1.
- **Ladder step per bit i.** Two multipliers run in parallel every step.
  - If exp[i]=0: R1 <= R0*R1 mod n and R0 <= R0*R0 mod n.
  - If exp[i]=1: R0 <= R0*R1 mod n and R1 <= R1*R1 mod n.
  - Both products are always computed, so there is no data-dependent skip.
- **Modular multiply a*b mod n.** Two identical units, MSB-first over the 2*WIDTH bits of a, one bit per cycle.
  - acc' = 2*acc + (a[j] ? b : 0).
  - acc' < 3n, so the accumulator is 2*WIDTH+2 bits wide.
  - Both acc'-n and acc'-2n are always computed; a mux selects the correct one (result < n).
  - No early exit on leading zeros.
- **MUL.** Runs 2*WIDTH cycles, then goes to STEP.
- **STEP.** Writes R0/R1 from the multiplier results.
  - If i==0, go to DONE.
  - Otherwise decrement i and go back to MUL.
- **DONE.** out <= R0 and finish=1 for this single cycle, then go to IDLE. If start=1 in DONE, go to INIT instead (back-to-back operation).
- **n==0.** out=0; latency unchanged.
- **base >= n.** out is undefined; latency is still unchanged and no lock-up occurs.
- **Reset.** rst_n=0 at any clock edge, including mid-operation: go to IDLE, out=0, finish=0, busy=0, R0=R1=acc=0, i=0.

## Timing
- Cycle 0 is the edge where start is accepted.
- finish is high in the cycle following edge LAT = 4*WIDTH^2 + 2*WIDTH + 2. LAT = 274 for WIDTH=8, identical for every base, exp and n.
- busy rises the cycle after acceptance and stays high through INIT, MUL and STEP. It is low in DONE and IDLE.
- start while busy=1 is ignored; there is no queueing.
- out holds its value from the finish cycle until the next DONE or a reset.
- finish is never high for two consecutive cycles, even with back-to-back starts.

## Test plan
- **Encrypt.** WIDTH=8, n=143, exp=7, base=5 -> out=47, finish exactly 274 cycles after start, busy low in the finish cycle.
- **Decrypt.** n=143, exp=103, base=47 -> out=5. Also sweep every base 0..142 with exp=7 then exp=103, checking the round trip returns the original base each time.
- **Constant time.** exp=0x0000 vs exp=0xFFFF and base=0 vs base=142, with n=143:
  - All four runs have a latency of exactly 274 cycles.
  - exp=0 gives out=1.
  - base=0 with exp>0 gives out=0.
- **Edge moduli.** n=1 with any base/exp -> out=0. n=0 -> out=0. Both with latency 274.
- **Handshake.**
  - A start pulse during busy at cycle 100 is ignored: one finish at cycle 274, no second finish.
  - A start held high through the DONE cycle launches a second run: the second finish comes 274 cycles after the first.
- **Reset mid-operation.** rst_n=0 for one cycle at cycle 150 -> the next cycle shows busy=0, finish=0, out=0, with no finish pulse afterwards. A fresh start then produces the correct result with latency 274.

Source files
------------

// File: rtl/mod_exp_ct_if.sv
// Request/response bundle for mod_exp_ct: operands and start in, result,
// busy and finish out. Signal prefixes are from the exponentiator's viewpoint.
interface mod_exp_ct_if #(
  parameter int WIDTH = 8
);
  logic               i_start;
  logic [2*WIDTH-1:0] i_base;
  logic [2*WIDTH-1:0] i_exp;
  logic [2*WIDTH-1:0] i_n;
  logic [2*WIDTH-1:0] o_out;
  logic               o_busy;
  logic               o_finish;

  modport master (
    output i_start, i_base, i_exp, i_n,
    input  o_out, o_busy, o_finish
  );

  modport slave (
    input  i_start, i_base, i_exp, i_n,
    output o_out, o_busy, o_finish
  );
endinterface

// File: rtl/mod_exp_ct.sv
// Constant-time modular exponentiator: Montgomery ladder over every exponent
// bit, each step driving two shift-add modular multipliers in lockstep.
module mod_exp_ct #(
  parameter int WIDTH = 8
) (
  input logic         i_clk,
  input logic         i_rst_n,
  mod_exp_ct_if.slave bus
);

  localparam int DW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;
  localparam int CW = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MUL  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_base;
  logic [DW-1:0]   r_exp;
  logic [DW-1:0]   r_n;
  logic [DW-1:0]   r_r0;
  logic [DW-1:0]   r_r1;
  logic [AW-1:0]   r_acc_p;
  logic [AW-1:0]   r_acc_s;
  logic [CW-1:0]   r_i;
  logic [CW-1:0]   r_j;
  logic [DW-1:0]   r_out;
  logic            r_busy;
  logic            r_finish;

  logic            w_bit_e;
  logic [DW-1:0]   w_sq_op;
  logic [AW-1:0]   w_acc_p_nxt;
  logic [AW-1:0]   w_acc_s_nxt;
  logic            w_accept;
  logic [DW-1:0]   w_r0_init;

  // One shift-add step: 2*acc + (a_bit ? b : 0) reduced below m. Both
  // candidate subtractions are always formed so timing never depends on data.
  function automatic logic [AW-1:0] f_mod_step(
    input logic [AW-1:0] acc,
    input logic          a_bit,
    input logic [DW-1:0] b,
    input logic [DW-1:0] m
  );
    logic [AW+1:0] t;
    logic [AW+1:0] d1;
    logic [AW+1:0] d2;
    logic [AW-1:0] res;
    t  = {1'b0, acc, 1'b0} + (a_bit ? {4'b0000, b} : {(AW+2){1'b0}});
    d1 = t - {4'b0000, m};
    d2 = t - {3'b000, m, 1'b0};
    if (!d2[AW+1]) begin
      res = d2[AW-1:0];
    end else if (!d1[AW+1]) begin
      res = d1[AW-1:0];
    end else begin
      res = t[AW-1:0];
    end
    return res;
  endfunction

  // Product unit always computes R0*R1; the square unit squares whichever
  // register the current exponent bit selects.
  assign w_bit_e     = r_exp[r_i];
  assign w_sq_op     = w_bit_e ? r_r1 : r_r0;
  assign w_acc_p_nxt = f_mod_step(r_acc_p, r_r0[r_j], r_r1, r_n);
  assign w_acc_s_nxt = f_mod_step(r_acc_s, w_sq_op[r_j], w_sq_op, r_n);
  assign w_accept    = bus.i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_r0_init   = (r_n == DW'(1)) ? {DW{1'b0}} : DW'(1);

  // Sequencer plus ladder/multiplier datapath with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_base   <= {DW{1'b0}};
      r_exp    <= {DW{1'b0}};
      r_n      <= {DW{1'b0}};
      r_r0     <= {DW{1'b0}};
      r_r1     <= {DW{1'b0}};
      r_acc_p  <= {AW{1'b0}};
      r_acc_s  <= {AW{1'b0}};
      r_i      <= {CW{1'b0}};
      r_j      <= {CW{1'b0}};
      r_out    <= {DW{1'b0}};
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base  <= bus.i_base;
            r_exp   <= bus.i_exp;
            r_n     <= bus.i_n;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_INIT: begin
          r_r0    <= w_r0_init;
          r_r1    <= r_base;
          r_i     <= CW'(DW - 1);
          r_j     <= CW'(DW - 1);
          r_acc_p <= {AW{1'b0}};
          r_acc_s <= {AW{1'b0}};
          r_state <= S_MUL;
        end
        S_MUL: begin
          r_acc_p <= w_acc_p_nxt;
          r_acc_s <= w_acc_s_nxt;
          if (r_j == {CW{1'b0}}) begin
            r_state <= S_STEP;
          end else begin
            r_j     <= r_j - CW'(1);
            r_state <= S_MUL;
          end
        end
        S_STEP: begin
          if (w_bit_e) begin
            r_r0 <= r_acc_p[DW-1:0];
            r_r1 <= r_acc_s[DW-1:0];
          end else begin
            r_r0 <= r_acc_s[DW-1:0];
            r_r1 <= r_acc_p[DW-1:0];
          end
          r_acc_p <= {AW{1'b0}};
          r_acc_s <= {AW{1'b0}};
          r_j     <= CW'(DW - 1);
          if (r_i == {CW{1'b0}}) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_i     <= r_i - CW'(1);
            r_state <= S_MUL;
          end
        end
        S_DONE: begin
          // A zero modulus has no meaningful residue; report 0.
          r_out    <= (r_n == {DW{1'b0}}) ? {DW{1'b0}} : r_r0;
          r_finish <= 1'b1;
          if (w_accept) begin
            r_base  <= bus.i_base;
            r_exp   <= bus.i_exp;
            r_n     <= bus.i_n;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_out    = r_out;
  assign bus.o_busy   = r_busy;
  assign bus.o_finish = r_finish;

endmodule
